// File: rtl/perm_out_serializer.sv
// Streams a full 1600-bit Keccak state as NCHUNK indexed chunks on the doutix/dout/pushout bus.
// An active slot plus a pending slot let the next state be accepted while the current one streams.
module perm_out_serializer #(
   parameter int NCHUNK  = 8,
   parameter int CHUNK_W = 200,
   parameter int IX_W    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NCHUNK*CHUNK_W-1:0] state_in,
   input  logic                      state_valid,
   output logic                      state_ready,
   input  logic                      stopin,
   output logic [IX_W-1:0]           doutix,
   output logic [CHUNK_W-1:0]        dout,
   output logic                      pushout,
   output logic                      busy
);

   localparam int SW = NCHUNK * CHUNK_W;
   localparam logic [IX_W-1:0] LAST_IX = IX_W'(NCHUNK - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } fsm_t;

   fsm_t            state_q, state_d;
   logic [IX_W-1:0] count_q, count_d;
   logic [SW-1:0]   active_q, active_d;
   logic [SW-1:0]   pending_q, pending_d;
   logic            pend_full_q, pend_full_d;

   logic                accept, deliver;
   logic                pushout_d;
   logic [IX_W-1:0]     doutix_d;
   logic [CHUNK_W-1:0]  dout_d;

   // Handshakes: a state transfers at a rising edge with state_valid && state_ready;
   // a beat transfers at a rising edge with pushout && !stopin. Ready depends only on a flop.
   assign state_ready = !pend_full_q;
   assign accept      = state_valid && state_ready;
   assign deliver     = pushout && !stopin;
   assign busy        = (state_q == STREAM);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      active_d    = active_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               active_d = state_in;
               count_d  = '0;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (deliver && (count_q == LAST_IX)) begin
               // Pending always wins; it can never coincide with an accept since ready was low.
               count_d = '0;
               if (pend_full_q) begin
                  active_d    = pending_q;
                  pend_full_d = 1'b0;
               end else if (accept) begin
                  active_d = state_in;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (deliver) count_d = count_q + 1'b1;
               if (accept) begin
                  pending_d   = state_in;
                  pend_full_d = 1'b1;
               end
            end
         end
      endcase
   end

   // Outputs are registered from the next-state view so they hold while stalled.
   always_comb begin
      pushout_d = (state_d == STREAM);
      doutix_d  = '0;
      dout_d    = '0;
      if (pushout_d) begin
         doutix_d = count_d;
         dout_d   = active_d[CHUNK_W*count_d +: CHUNK_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_full_q <= 1'b0;
         pushout     <= 1'b0;
         doutix      <= '0;
         dout        <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pend_full_q <= pend_full_d;
         pushout     <= pushout_d;
         doutix      <= doutix_d;
         dout        <= dout_d;
      end
   end

endmodule

// File: tb/tb_perm_out_serializer.sv
// Bench for perm_out_serializer: directed and random steps checked against a queue of expected beats.
// The model says: a beat is presented whenever undelivered beats exist; ready while at most one state is in flight.
module tb_perm_out_serializer;

   localparam int NCHUNK  = 8;
   localparam int CHUNK_W = 200;
   localparam int IX_W    = 3;
   localparam int SW      = NCHUNK * CHUNK_W;
   localparam int BW      = IX_W + CHUNK_W;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [SW-1:0]       state_in = '0;
   logic                state_valid = 1'b0;
   logic                state_ready;
   logic                stopin = 1'b0;
   logic [IX_W-1:0]     doutix;
   logic [CHUNK_W-1:0]  dout;
   logic                pushout;
   logic                busy;

   int checks = 0;
   int failures = 0;
   int pushes_seen = 0;
   int dut_acc = 0;
   logic [BW-1:0] exp_q[$];

   perm_out_serializer #(.NCHUNK(NCHUNK), .CHUNK_W(CHUNK_W), .IX_W(IX_W)) dut (
      .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
      .state_ready(state_ready), .stopin(stopin), .doutix(doutix), .dout(dout),
      .pushout(pushout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] d;
      for (int w = 0; w < SW / 32; w++) d[w*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [SW-1:0] pattern_state();
      logic [SW-1:0] d;
      for (int i = 0; i < NCHUNK; i++) d[i*CHUNK_W +: CHUNK_W] = {25{8'(i + 1)}};
      return d;
   endfunction

   task automatic check_outputs();
      logic mp;
      logic [BW-1:0] head;
      mp = (exp_q.size() > 0);
      if (pushout === 1'b1) pushes_seen++;
      chk("pushout", pushout, mp);
      chk("busy", busy, mp);
      chk("state_ready", state_ready, exp_q.size() <= NCHUNK);
      if (mp) begin
         head = exp_q[0];
         chk("doutix", doutix, head[BW-1:CHUNK_W]);
         chk("dout", dout, head[CHUNK_W-1:0]);
      end else begin
         chk("doutix_idle", doutix, '0);
         chk("dout_idle", dout, '0);
      end
   endtask

   // One clock: check what is presented, drive inputs, advance the model across the coming edge.
   task automatic step(input logic v, input logic s, input logic [SW-1:0] d);
      logic acc, dlv;
      @(negedge clk);
      check_outputs();
      state_valid = v;
      stopin      = s;
      state_in    = d;
      if (v && state_ready === 1'b1) dut_acc++;
      acc = v && (exp_q.size() <= NCHUNK);
      dlv = (exp_q.size() > 0) && !s;
      if (dlv) void'(exp_q.pop_front());
      if (acc)
         for (int i = 0; i < NCHUNK; i++)
            exp_q.push_back({IX_W'(i), d[i*CHUNK_W +: CHUNK_W]});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_pushout", pushout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", state_ready, 1'b1);
      chk("rst_doutix", doutix, '0);
      chk("rst_dout", dout, '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Single patterned state
      pushes_seen = 0;
      step(1'b1, 1'b0, pattern_state());
      idle(12);
      chk("single_push_cycles", pushes_seen, 8);

      // Back-to-back A then B
      pushes_seen = 0;
      step(1'b1, 1'b0, rand_state());
      step(1'b1, 1'b0, rand_state());
      idle(20);
      chk("b2b_push_cycles", pushes_seen, 16);

      // Stall three cycles while beat 4 is presented
      pushes_seen = 0;
      step(1'b1, 1'b0, rand_state());
      idle(4);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0);
      idle(15);
      chk("stall_push_cycles", pushes_seen, 11);

      // Accept coinciding with last-beat delivery, pending empty
      pushes_seen = 0;
      step(1'b1, 1'b0, rand_state());
      idle(7);
      step(1'b1, 1'b0, rand_state());
      idle(12);
      chk("same_edge_push_cycles", pushes_seen, 16);

      // Asynchronous reset while doutix=3
      step(1'b1, 1'b0, rand_state());
      idle(3);
      @(negedge clk);
      check_outputs();
      chk("pre_reset_doutix", doutix, 3);
      state_valid = 1'b0;
      stopin = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("async_rst_pushout", pushout, 1'b0);
      chk("async_rst_dout", dout, '0);
      chk("async_rst_doutix", doutix, '0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_ready", state_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 1'b0, rand_state());
      idle(12);

      // Valid held high under a permanent stall
      dut_acc = 0;
      for (int k = 0; k < 10; k++) step(1'b1, 1'b1, rand_state());
      chk("held_accepts", dut_acc, 2);
      chk("held_doutix", doutix, 0);
      idle(20);

      // Random traffic
      for (int k = 0; k < 400; k++)
         step(($urandom_range(1, 0) == 1), ($urandom_range(3, 0) == 0), rand_state());
      idle(24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
